// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: each 32-bit load/store is split into two 16-bit accesses
// to an external asynchronous SRAM with programmable wait states.
`default_nettype none

module mem_stage_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_value,
    output logic        ready,
    output logic [31:0] MEM_result,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] word_q, word_d;
    logic [15:0] hi_data_q, hi_data_d;
    logic        wr_q, wr_d;
    logic [31:0] result_q, result_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] dq_q, dq_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;

    logic        req;
    logic [31:0] off;
    logic        unused_off;

    assign req        = MEM_R_EN | MEM_W_EN;
    assign off        = ALU_result - BASE_ADDR;
    // Accesses are word-aligned and the address wraps at the SRAM size.
    assign unused_off = ^{off[31:19], off[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            word_q    <= 17'd0;
            hi_data_q <= 16'd0;
            wr_q      <= 1'b0;
            result_q  <= 32'd0;
            addr_q    <= 18'd0;
            dq_q      <= 16'd0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            hi_data_q <= hi_data_d;
            wr_q      <= wr_d;
            result_q  <= result_d;
            addr_q    <= addr_d;
            dq_q      <= dq_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
        end
    end

    // SRAM pins are registered so they change together with the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        hi_data_d = hi_data_q;
        wr_d      = wr_q;
        result_d  = result_q;
        addr_d    = addr_q;
        dq_d      = dq_q;
        we_n_d    = we_n_q;
        oe_n_d    = oe_n_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d   = S_LO;
                    cnt_d     = 4'd0;
                    word_d    = off[18:2];
                    hi_data_d = ST_value[31:16];
                    wr_d      = MEM_W_EN;
                    addr_d    = {off[18:2], 1'b0};
                    if (MEM_W_EN) begin
                        dq_d   = ST_value[15:0];
                        we_n_d = 1'b0;
                        oe_n_d = 1'b1;
                    end else begin
                        we_n_d = 1'b1;
                        oe_n_d = 1'b0;
                    end
                end
            end
            S_LO: begin
                if (cnt_q == LAST_CNT) begin
                    if (!wr_q) begin
                        result_d[15:0] = sram_dq_in;
                    end else begin
                        dq_d = hi_data_q;
                    end
                    state_d = S_HI;
                    cnt_d   = 4'd0;
                    addr_d  = {word_q, 1'b1};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HI: begin
                if (cnt_q == LAST_CNT) begin
                    if (!wr_q) begin
                        result_d[31:16] = sram_dq_in;
                    end
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // The request still visible here is the one just finished.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ready = 1'b1;
        if (rst) begin
            case (state_q)
                S_IDLE:  ready = ~req;
                S_LO:    ready = 1'b0;
                S_HI:    ready = 1'b0;
                default: ready = 1'b1;
            endcase
        end
    end

    assign MEM_result  = result_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule

`default_nettype wire
